// File: rtl/if_id_buffer_if.sv
// Handshake bundle between fetch, the IF/ID buffer and decode.
//   fetch side : pc_in, instr_in, in_valid -> buffer ; in_ready <- buffer
//   control    : flush -> buffer
//   decode side: out_pc, out_pc4, out_instr, out_valid <- buffer ; out_ready -> buffer
//   status     : occupancy <- buffer
// master: the environment (fetch/decode/control). slave: the buffer itself.
interface if_id_buffer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_in;
    logic [WIDTH-1:0] instr_in;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_pc4;
    logic [WIDTH-1:0] out_instr;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       occupancy;

    modport master (
        output pc_in, instr_in, in_valid, flush, out_ready,
        input  in_ready, out_pc, out_pc4, out_instr, out_valid, occupancy
    );

    modport slave (
        input  pc_in, instr_in, in_valid, flush, out_ready,
        output in_ready, out_pc, out_pc4, out_instr, out_valid, occupancy
    );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID pipeline buffer.
// Captures {pc, instr} from fetch, precomputes pc + PC_INC, and presents the
// oldest entry to decode. Valid/ready on both sides; synchronous flush.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - if_id_buffer_if slave modport (fetch/decode handshake, flush, occupancy)
module if_id_buffer #(
    parameter int WIDTH  = 32,
    parameter int PC_INC = 4
) (
    input  logic          clk,
    input  logic          rst,
    if_id_buffer_if.slave bus
);
    logic [WIDTH-1:0] pc_q    [2];
    logic [WIDTH-1:0] pc4_q   [2];
    logic [WIDTH-1:0] instr_q [2];
    logic [1:0]       count;
    logic             rd_ptr;
    logic             wr_ptr;
    logic             push;
    logic             pop;
    logic             not_empty;

    assign not_empty = (count != 2'd0);

    // in_ready depends only on registered count, never on out_ready.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = not_empty;
    assign bus.occupancy = count;

    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop  = not_empty & bus.out_ready & ~bus.flush;

    // Empty buffer presents all zeros (a NOP) rather than stale entry data.
    always_comb begin
        bus.out_pc    = '0;
        bus.out_pc4   = '0;
        bus.out_instr = '0;
        if (not_empty) begin
            bus.out_pc    = pc_q[rd_ptr];
            bus.out_pc4   = pc4_q[rd_ptr];
            bus.out_instr = instr_q[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (bus.flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    // Entry storage; contents are left as-is on flush since count gates them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                pc_q[i]    <= '0;
                pc4_q[i]   <= '0;
                instr_q[i] <= '0;
            end
        end else if (push) begin
            pc_q[wr_ptr]    <= bus.pc_in;
            pc4_q[wr_ptr]   <= bus.pc_in + WIDTH'(PC_INC);
            instr_q[wr_ptr] <= bus.instr_in;
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus randomized
// traffic, compared against a queue-based model of the buffer contents.
module tb_if_id_buffer;
    logic clk;
    logic rst;

    if_id_buffer_if #(.WIDTH(32)) bus ();

    if_id_buffer #(.WIDTH(32), .PC_INC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        ent_t h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        check_val("occupancy", 32'(bus.occupancy), 32'(mq.size()));
        check_val("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check_val("in_ready",  32'(bus.in_ready),  32'(mq.size() != 2));
        check_val("out_pc",    bus.out_pc,    h.pc);
        check_val("out_pc4",   bus.out_pc4,   (mq.size() != 0) ? h.pc + 32'd4 : 32'd0);
        check_val("out_instr", bus.out_instr, h.instr);
    endtask

    // Called at a falling edge: checks current outputs, drives one cycle of
    // inputs, advances the model and moves to the next falling edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl);
        bit do_push;
        bit do_pop;
        check_outputs();
        bus.in_valid  = v;
        bus.pc_in     = pc;
        bus.instr_in  = ins;
        bus.out_ready = rdy;
        bus.flush     = fl;
        do_push = v && (mq.size() < 2) && !fl;
        do_pop  = (mq.size() > 0) && rdy && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{pc: pc, instr: ins});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.pc_in     = '0;
        bus.instr_in  = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // First push after reset, visible one edge later.
        step(1'b1, 32'h0040_0000, 32'h8C08_0004, 1'b1, 1'b0);
        check_val("first_pc4", bus.out_pc4, 32'h0040_0004);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: fill to two, third offer held off, then drain in order.
        step(1'b1, 32'h100, 32'hA100, 1'b0, 1'b0);
        step(1'b1, 32'h104, 32'hA104, 1'b0, 1'b0);
        step(1'b1, 32'h108, 32'hA108, 1'b0, 1'b0);
        check_val("full_ready", 32'(bus.in_ready), 32'd0);
        step(1'b1, 32'h108, 32'hA108, 1'b1, 1'b0);
        step(1'b1, 32'h108, 32'hA108, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        // Pop attempt on empty buffer changes nothing.
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming across pointer wrap.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b1, 1'b0);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while full, with a concurrent offer and ready.
        step(1'b1, 32'h1F0, 32'hB1F0, 1'b0, 1'b0);
        step(1'b1, 32'h1F4, 32'hB1F4, 1'b0, 1'b0);
        step(1'b1, 32'h200, 32'hB200, 1'b1, 1'b1);
        check_val("flush_valid", 32'(bus.out_valid), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // PC increment wraps at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 32'hC0DE, 1'b0, 1'b0);
        check_val("pc4_wrap", bus.out_pc4, 32'h0000_0000);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while full.
        step(1'b1, 32'h300, 32'hD300, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'hD304, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        mq.delete();
        check_outputs();
        #1 rst = 1'b0;
        @(negedge clk);
        step(1'b1, 32'h400, 32'hE400, 1'b0, 1'b0);
        check_val("post_rst_pc", bus.out_pc, 32'h400);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 4) != 0, $urandom, $urandom,
                 ($urandom % 3) != 0, ($urandom % 25) == 0);
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
